// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if
//   Bundles every signal around the register-file write arbiter: the WB-stage
//   write request, the long-latency (mul/div) result handshake, the issue
//   notification that marks a destination busy, the decode busy queries and
//   the resulting register-file write port.
//
//   Handshake rule for the lu_* channel: a result transfers in a cycle where
//   lu_valid and lu_ready are both high. Once lu_valid is raised, lu_valid,
//   lu_waddr and lu_wdata stay stable until that transfer; lu_ready may be
//   high while lu_valid is low and means nothing then. pipe_stall high means
//   the WB write presented this cycle was not taken and must be held.
//
//   modport master : pipeline / mul-div side (drives requests, sees results)
//   modport slave  : the arbiter itself
interface rf_write_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  pipe_wen;
    logic [ADDR_WIDTH-1:0] pipe_waddr;
    logic [DATA_WIDTH-1:0] pipe_wdata;
    logic                  pipe_stall;

    logic                  lu_valid;
    logic [ADDR_WIDTH-1:0] lu_waddr;
    logic [DATA_WIDTH-1:0] lu_wdata;
    logic                  lu_ready;

    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_waddr;

    logic [ADDR_WIDTH-1:0] rd_addr1;
    logic [ADDR_WIDTH-1:0] rd_addr2;
    logic                  rd_busy1;
    logic                  rd_busy2;

    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;

    modport master (
        output pipe_wen, pipe_waddr, pipe_wdata,
        output lu_valid, lu_waddr, lu_wdata,
        output issue_valid, issue_waddr,
        output rd_addr1, rd_addr2,
        input  pipe_stall, lu_ready, rd_busy1, rd_busy2,
        input  rf_wen, rf_waddr, rf_wdata
    );

    modport slave (
        input  pipe_wen, pipe_waddr, pipe_wdata,
        input  lu_valid, lu_waddr, lu_wdata,
        input  issue_valid, issue_waddr,
        input  rd_addr1, rd_addr2,
        output pipe_stall, lu_ready, rd_busy1, rd_busy2,
        output rf_wen, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the single register-file write port between the in-order WB stage
//   and the long-latency unit. WB normally has priority; if a long-latency
//   result waits STARVE_LIMIT cycles the arbiter enters FORCE for one cycle,
//   stalls the pipe and writes the long-latency result. A scoreboard tracks
//   destinations with an outstanding long-latency result for decode hazards.
//
// Ports
//   clk          clock, all state on posedge
//   rstn         synchronous active-low reset
//   bus          rf_write_arbiter_if.slave (pipe, lu, issue, rd query, rf port)
//   dbg_state    current FSM state (0 = NORMAL, 1 = FORCE)
//   dbg_wait_cnt cycles the current lu result has waited unserved
module rf_write_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                               clk,
    input  logic                               rstn,
    rf_write_arbiter_if.slave                  bus,
    output logic                               dbg_state,
    output logic [$clog2(STARVE_LIMIT+1)-1:0]  dbg_wait_cnt
);
    localparam int NREG = 2 ** ADDR_WIDTH;
    localparam int CW   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FORCE_AT = CW'(STARVE_LIMIT - 1);

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   wait_cnt;
    logic [NREG-1:0] busy, busy_nx;
    logic            lu_hs;

    // Arbitration and FSM next state. Reset gating is applied last so that
    // every output is quiet for as long as rstn is low.
    always_comb begin
        state_nx       = state;
        bus.rf_wen     = 1'b0;
        bus.rf_waddr   = bus.pipe_waddr;
        bus.rf_wdata   = bus.pipe_wdata;
        bus.lu_ready   = 1'b0;
        bus.pipe_stall = 1'b0;
        case (state)
            NORMAL: begin
                if (bus.pipe_wen) begin
                    bus.rf_wen = 1'b1;
                    // lu loses this cycle; escalate once it has waited long enough
                    if (bus.lu_valid && wait_cnt == FORCE_AT)
                        state_nx = FORCE;
                end else if (bus.lu_valid) begin
                    bus.rf_wen   = 1'b1;
                    bus.rf_waddr = bus.lu_waddr;
                    bus.rf_wdata = bus.lu_wdata;
                    bus.lu_ready = 1'b1;
                end
            end
            FORCE: begin
                // One-cycle state: a missing lu_valid is a protocol error and
                // simply writes nothing before returning to NORMAL.
                bus.pipe_stall = 1'b1;
                bus.lu_ready   = 1'b1;
                bus.rf_wen     = bus.lu_valid;
                bus.rf_waddr   = bus.lu_waddr;
                bus.rf_wdata   = bus.lu_wdata;
                state_nx       = NORMAL;
            end
            default: state_nx = NORMAL;
        endcase
        if (!rstn) begin
            bus.rf_wen     = 1'b0;
            bus.lu_ready   = 1'b0;
            bus.pipe_stall = 1'b0;
            state_nx       = NORMAL;
        end
    end

    assign lu_hs = bus.lu_valid && bus.lu_ready;

    // Clear first, then set, so a same-cycle issue to the address being
    // retired keeps the register busy for the new op. r0 is never tracked.
    always_comb begin
        busy_nx = busy;
        if (lu_hs)
            busy_nx[bus.lu_waddr] = 1'b0;
        if (bus.issue_valid && bus.issue_waddr != '0)
            busy_nx[bus.issue_waddr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= NORMAL;
            wait_cnt <= '0;
            busy     <= '0;
        end else begin
            state <= state_nx;
            busy  <= busy_nx;
            if (bus.lu_valid && !bus.lu_ready) begin
                if (wait_cnt != {CW{1'b1}})
                    wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Queries see registered state only; a clear lands the next cycle.
    assign bus.rd_busy1 = rstn && busy[bus.rd_addr1];
    assign bus.rd_busy2 = rstn && busy[bus.rd_addr2];

    assign dbg_state    = state;
    assign dbg_wait_cnt = wait_cnt;

    a_lu_stable: assert property (@(posedge clk) disable iff (!rstn)
        bus.lu_valid && !bus.lu_ready |=>
            bus.lu_valid && $stable(bus.lu_waddr) && $stable(bus.lu_wdata));

    a_issue_not_busy: assert property (@(posedge clk) disable iff (!rstn)
        bus.issue_valid && bus.issue_waddr != '0 |->
            !busy[bus.issue_waddr] || (lu_hs && bus.lu_waddr == bus.issue_waddr));
endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int LIMIT = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    rf_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    logic       dbg_state;
    logic [2:0] dbg_wait_cnt;

    rf_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .bus          (bus.slave),
        .dbg_state    (dbg_state),
        .dbg_wait_cnt (dbg_wait_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard of rf writes ----------------
    logic [AW+DW-1:0] exp_q[$];

    task automatic expect_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    always @(negedge clk) begin
        if (rstn && bus.rf_wen) begin
            if (exp_q.size() == 0) begin
                check("rf_unexpected_write", 1, 0);
            end else begin
                check("rf_write", {bus.rf_waddr, bus.rf_wdata}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.pipe_wen    = 1'b0;
        bus.pipe_waddr  = '0;
        bus.pipe_wdata  = '0;
        bus.lu_valid    = 1'b0;
        bus.lu_waddr    = '0;
        bus.lu_wdata    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_waddr = '0;
        bus.rd_addr1    = '0;
        bus.rd_addr2    = '0;
    endtask

    task automatic pipe(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.pipe_wen   = en;
        bus.pipe_waddr = a;
        bus.pipe_wdata = d;
    endtask

    task automatic lu(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.lu_valid = v;
        bus.lu_waddr = a;
        bus.lu_wdata = d;
    endtask

    task automatic issue(input logic v, input logic [AW-1:0] a);
        bus.issue_valid = v;
        bus.issue_waddr = a;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        idle_inputs();
        #1;

        // Reset with both requesters active: everything quiet.
        rstn = 1'b0;
        pipe(1'b1, 5'd1, 32'hA1);
        lu(1'b1, 5'd2, 32'hB2);
        bus.rd_addr1 = 5'd1;
        bus.rd_addr2 = 5'd2;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("rst_rf_wen", bus.rf_wen, 0);
            check("rst_lu_ready", bus.lu_ready, 0);
            check("rst_pipe_stall", bus.pipe_stall, 0);
            check("rst_rd_busy1", bus.rd_busy1, 0);
            check("rst_rd_busy2", bus.rd_busy2, 0);
            adv();
        end
        check("rst_state", dbg_state, 0);
        check("rst_wait_cnt", dbg_wait_cnt, 0);

        // First cycle after release grants the pipe.
        rstn = 1'b1;
        expect_write(5'd1, 32'hA1);
        settle();
        check("rel_rf_wen", bus.rf_wen, 1);
        check("rel_rf_waddr", bus.rf_waddr, 1);
        check("rel_lu_ready", bus.lu_ready, 0);
        adv();
        pipe(1'b0, 5'd0, 32'h0);
        expect_write(5'd2, 32'hB2);
        settle();
        check("rel_lu_ready2", bus.lu_ready, 1);
        check("rel_wait_cnt", dbg_wait_cnt, 1);
        adv();
        lu(1'b0, 5'd0, 32'h0);

        // Priority: pipe wins, lu served the next idle cycle.
        pipe(1'b1, 5'd3, 32'h11);
        lu(1'b1, 5'd5, 32'h22);
        expect_write(5'd3, 32'h11);
        settle();
        check("prio_waddr", bus.rf_waddr, 3);
        check("prio_wdata", bus.rf_wdata, 32'h11);
        check("prio_lu_ready", bus.lu_ready, 0);
        check("prio_stall", bus.pipe_stall, 0);
        adv();
        pipe(1'b0, 5'd0, 32'h0);
        expect_write(5'd5, 32'h22);
        settle();
        check("prio_lu_waddr", bus.rf_waddr, 5);
        check("prio_lu_wdata", bus.rf_wdata, 32'h22);
        check("prio_lu_ready2", bus.lu_ready, 1);
        adv();
        lu(1'b0, 5'd0, 32'h0);
        settle();
        check("idle_rf_wen", bus.rf_wen, 0);
        check("idle_wait_cnt", dbg_wait_cnt, 0);
        adv();

        // Starvation: pipe every cycle, lu forced in on cycle LIMIT.
        lu(1'b1, 5'd6, 32'h66);
        for (int c = 0; c < 6; c++) begin
            pipe(1'b1, AW'(10 + c), DW'(32'h100 + c));
            if (c == 4) begin
                expect_write(5'd6, 32'h66);
                settle();
                check("force_state", dbg_state, 1);
                check("force_stall", bus.pipe_stall, 1);
                check("force_lu_ready", bus.lu_ready, 1);
                check("force_waddr", bus.rf_waddr, 6);
                adv();
                lu(1'b0, 5'd0, 32'h0);
            end else begin
                expect_write(AW'(10 + c), DW'(32'h100 + c));
                settle();
                check("starve_stall", bus.pipe_stall, 0);
                check("starve_lu_ready", bus.lu_ready, 0);
                check("starve_waddr", bus.rf_waddr, 64'(10 + c));
                check("starve_wait_cnt", dbg_wait_cnt, (c < 4) ? 64'(c) : 64'd0);
                check("starve_state", dbg_state, 0);
                adv();
            end
        end
        pipe(1'b0, 5'd0, 32'h0);

        // Scoreboard set/clear, pipe write to busy reg, r0 never busy.
        issue(1'b1, 5'd7);
        bus.rd_addr1 = 5'd7;
        bus.rd_addr2 = 5'd0;
        settle();
        check("sb_busy_before", bus.rd_busy1, 0);
        adv();
        issue(1'b0, 5'd0);
        pipe(1'b1, 5'd7, 32'h77);
        expect_write(5'd7, 32'h77);
        settle();
        check("sb_busy_set", bus.rd_busy1, 1);
        check("sb_pipe_busy_waddr", bus.rf_waddr, 7);
        adv();
        pipe(1'b0, 5'd0, 32'h0);
        lu(1'b1, 5'd7, 32'h7A);
        expect_write(5'd7, 32'h7A);
        settle();
        check("sb_busy_kept", bus.rd_busy1, 1);
        check("sb_lu_ready", bus.lu_ready, 1);
        adv();
        lu(1'b0, 5'd0, 32'h0);
        issue(1'b1, 5'd0);
        settle();
        check("sb_busy_cleared", bus.rd_busy1, 0);
        adv();
        issue(1'b0, 5'd0);
        pipe(1'b1, 5'd0, 32'h55);
        expect_write(5'd0, 32'h55);
        settle();
        check("sb_r0_busy", bus.rd_busy2, 0);
        check("r0_rf_wen", bus.rf_wen, 1);
        adv();
        pipe(1'b0, 5'd0, 32'h0);

        // Same-cycle retire and re-issue of r9: set wins.
        issue(1'b1, 5'd9);
        bus.rd_addr1 = 5'd9;
        adv();
        lu(1'b1, 5'd9, 32'h99);
        expect_write(5'd9, 32'h99);
        settle();
        check("same_busy_now", bus.rd_busy1, 1);
        check("same_lu_ready", bus.lu_ready, 1);
        adv();
        issue(1'b0, 5'd0);
        lu(1'b0, 5'd0, 32'h0);
        settle();
        check("same_busy_after", bus.rd_busy1, 1);
        adv();
        lu(1'b1, 5'd9, 32'h9A);
        expect_write(5'd9, 32'h9A);
        adv();
        lu(1'b0, 5'd0, 32'h0);
        settle();
        check("same_busy_final", bus.rd_busy1, 0);
        adv();

        // Reset while in FORCE.
        issue(1'b1, 5'd4);
        bus.rd_addr2 = 5'd4;
        adv();
        issue(1'b0, 5'd0);
        lu(1'b1, 5'd4, 32'h44);
        for (int c = 0; c < 4; c++) begin
            pipe(1'b1, AW'(20 + c), DW'(32'h200 + c));
            expect_write(AW'(20 + c), DW'(32'h200 + c));
            if (c == 0) begin
                settle();
                check("rf_busy_r4", bus.rd_busy2, 1);
            end
            adv();
        end
        rstn = 1'b0;
        settle();
        check("rstf_state_reg", dbg_state, 1);
        check("rstf_rf_wen", bus.rf_wen, 0);
        check("rstf_lu_ready", bus.lu_ready, 0);
        check("rstf_stall", bus.pipe_stall, 0);
        adv();
        idle_inputs();
        bus.rd_addr2 = 5'd4;
        rstn = 1'b1;
        settle();
        check("rstf_state", dbg_state, 0);
        check("rstf_busy", bus.rd_busy2, 0);
        check("rstf_wait_cnt", dbg_wait_cnt, 0);
        adv();

        check("exp_q_empty", 64'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
